// File: rtl/axi_lite_read_poller_pkg.sv
// Shared definitions for the AXI-Lite read poller: FSM encoding and RRESP codes.
// No logic; latency n/a.
// Backpressure n/a.
package axi_lite_read_poller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    function automatic logic resp_is_okay(input logic [1:0] resp);
        return resp == RRESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_lite_read_poller_poll_tick_gen.sv
// Free-running period timer: one-cycle tick each POLL_PERIOD cycles while enabled.
// Tick is decoded from the counter register in the wrap cycle.
// No backpressure; disabling clears the count so the next period starts fresh.
module poll_tick_gen
    import axi_lite_read_poller_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/axi_lite_read_poller.sv
// AXI-Lite master issuing single reads of TARGET_ADDR on start, poll tick or pending retry.
// Latency: start at cycle 0 -> ARVALID 1, RREADY 2, data_valid/err_pulse 3 (zero-wait slave).
// Waits indefinitely on ARREADY/RVALID; a sticky timeout flags slow slaves without aborting.
module axi_lite_read_poller
    import axi_lite_read_poller_pkg::*;
#(
    parameter int unsigned                  C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                  C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] TARGET_ADDR       = 32'h0000_0000,
    parameter int unsigned                  POLL_PERIOD        = 1000,
    parameter int unsigned                  TIMEOUT_CYCLES     = 256
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic                          start,
    input  logic                          poll_en,
    output logic                          M_AXI_ARVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    input  logic                          M_AXI_ARREADY,
    input  logic                          M_AXI_RVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    output logic                          M_AXI_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] data_out,
    output logic                          data_valid,
    output logic                          err_pulse,
    output logic                          timeout,
    output logic                          busy,
    output logic [15:0]                   read_count
);

    localparam int unsigned     TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                          state_q, state_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_out_q, data_out_d;
    logic                            data_valid_q, data_valid_d;
    logic                            err_pulse_q, err_pulse_d;
    logic                            timeout_q, timeout_d;
    logic                            busy_q, busy_d;
    logic [15:0]                     read_count_q, read_count_d;
    logic                            pending_q, pending_d;
    logic [TW-1:0]                   to_cnt_q, to_cnt_d;

    logic poll_tick;
    logic new_trig;

    poll_tick_gen #(
        .POLL_PERIOD (POLL_PERIOD)
    ) u_poll_tick_gen (
        .clk   (M_AXI_ACLK),
        .rst_n (M_AXI_ARESETN),
        .en    (poll_en),
        .tick  (poll_tick)
    );

    assign new_trig = start || poll_tick;

    always_comb begin
        state_d      = state_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        err_pulse_d  = 1'b0;
        timeout_d    = timeout_q;
        read_count_d = read_count_q;
        pending_d    = pending_q;
        to_cnt_d     = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                end
                // start and tick together still collapse into a single read
                if (new_trig || pending_q) begin
                    state_d   = ST_ADDR;
                    arvalid_d = 1'b1;
                    pending_d = 1'b0;
                    to_cnt_d  = '0;
                end
            end
            ST_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    state_d   = ST_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            ST_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    state_d      = ST_IDLE;
                    rready_d     = 1'b0;
                    read_count_d = read_count_q + 16'd1;
                    if (resp_is_okay(M_AXI_RRESP)) begin
                        data_out_d   = M_AXI_RDATA;
                        data_valid_d = 1'b1;
                    end else begin
                        err_pulse_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase

        // Outstanding transaction: remember one trigger, age the timeout counter.
        if (state_q != ST_IDLE) begin
            if (new_trig) begin
                pending_d = 1'b1;
            end
            if (to_cnt_q != TO_MAX) begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
            if (to_cnt_q == TO_LAST) begin
                timeout_d = 1'b1;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            read_count_q <= '0;
            pending_q    <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            err_pulse_q  <= err_pulse_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            read_count_q <= read_count_d;
            pending_q    <= pending_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    assign M_AXI_ARADDR  = TARGET_ADDR;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign data_out      = data_out_q;
    assign data_valid    = data_valid_q;
    assign err_pulse     = err_pulse_q;
    assign timeout       = timeout_q;
    assign busy          = busy_q;
    assign read_count    = read_count_q;

endmodule

// File: tb/tb_axi_lite_read_poller.sv
// Directed bench for axi_lite_read_poller: good/error reads, polling, timeout,
// pending collapse, start+tick coincidence and mid-transaction reset.
module tb_axi_lite_read_poller;

    localparam logic [31:0] TADDR = 32'h4000_0010;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic        poll_en = 1'b0;
    logic        arready = 1'b0;
    logic        rvalid  = 1'b0;
    logic [31:0] rdata   = 32'h0;
    logic [1:0]  rresp   = 2'b00;

    logic        arvalid;
    logic [31:0] araddr;
    logic        rready;
    logic [31:0] data_out;
    logic        data_valid;
    logic        err_pulse;
    logic        timeout;
    logic        busy;
    logic [15:0] read_count;

    int tests  = 0;
    int failed = 0;
    int rises  = 0;
    int dvs    = 0;
    int lows   = 0;

    axi_lite_read_poller #(
        .C_M_AXI_ADDR_WIDTH (32),
        .C_M_AXI_DATA_WIDTH (32),
        .TARGET_ADDR        (TADDR),
        .POLL_PERIOD        (10),
        .TIMEOUT_CYCLES     (256)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .start         (start),
        .poll_en       (poll_en),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARREADY (arready),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RREADY  (rready),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .err_pulse     (err_pulse),
        .timeout       (timeout),
        .busy          (busy),
        .read_count    (read_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step one cycle while tallying ARVALID rises, data_valid pulses and ARVALID-low cycles.
    task automatic step_cnt();
        logic prev;
        prev = arvalid;
        step();
        if (arvalid && !prev) rises++;
        if (data_valid) dvs++;
        if (!arvalid) lows++;
    endtask

    initial begin
        int bad_gap;
        int last_rise;
        logic prev;

        // Reset state
        repeat (3) step();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_data_valid", data_valid, 1'b0);
        chk1("rst_err_pulse", err_pulse, 1'b0);
        chk1("rst_timeout", timeout, 1'b0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_read_count", 32'(read_count), 32'd0);
        chk("araddr_in_reset", araddr, TADDR);
        rst_n = 1'b1;
        step();
        step();

        // Good read with zero-wait slave: latency 1/2/3
        arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("lat_arvalid_c1", arvalid, 1'b1);
        chk1("lat_busy_c1", busy, 1'b1);
        step();
        chk1("lat_arvalid_c2", arvalid, 1'b0);
        chk1("lat_rready_c2", rready, 1'b1);
        step();
        chk1("good_data_valid", data_valid, 1'b1);
        chk("good_data_out", data_out, 32'hDEADBEEF);
        chk("good_read_count", 32'(read_count), 32'd1);
        chk1("good_err_pulse", err_pulse, 1'b0);
        chk1("good_rready_low", rready, 1'b0);
        chk1("good_busy_low", busy, 1'b0);
        step();
        chk1("good_dv_one_cycle", data_valid, 1'b0);

        // SLVERR read
        rresp = 2'b10; rdata = 32'h12345678;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk1("err_err_pulse", err_pulse, 1'b1);
        chk1("err_data_valid", data_valid, 1'b0);
        chk("err_data_out_held", data_out, 32'hDEADBEEF);
        chk("err_read_count", 32'(read_count), 32'd2);
        step();
        chk1("err_pulse_one_cycle", err_pulse, 1'b0);

        // Periodic polling: period 10, 100 cycles
        rresp = 2'b00; rdata = 32'h5A5A_0001;
        poll_en = 1'b1;
        rises = 0; dvs = 0; bad_gap = 0; last_rise = -1;
        for (int c = 1; c <= 100; c++) begin
            prev = arvalid;
            step();
            if (arvalid && !prev) begin
                if (last_rise >= 0 && (c - last_rise) != 10) bad_gap++;
                last_rise = c;
                rises++;
            end
            if (data_valid) dvs++;
        end
        poll_en = 1'b0;
        chk("poll_rises", 32'(rises), 32'd10);
        chk("poll_bad_gaps", 32'(bad_gap), 32'd0);
        chk("poll_last_rise", 32'(last_rise), 32'd100);
        rises = 0;
        repeat (20) step_cnt();
        chk("poll_off_rises", 32'(rises), 32'd0);
        chk("poll_dv_pulses", 32'(dvs), 32'd10);
        chk("poll_read_count", 32'(read_count), 32'd12);
        chk("poll_data_out", data_out, 32'h5A5A_0001);

        // Timeout with ARREADY held low for 300 cycles
        arready = 1'b0; rdata = 32'hCAFEF00D;
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("to_arvalid_rise", arvalid, 1'b1);
        lows = 0;
        repeat (255) step_cnt();
        chk1("to_before_256", timeout, 1'b0);
        step_cnt();
        chk1("to_at_256", timeout, 1'b1);
        repeat (44) step_cnt();
        chk("to_arvalid_never_low", 32'(lows), 32'd0);
        arready = 1'b1;
        step();
        chk1("to_rready_after_ar", rready, 1'b1);
        step();
        chk1("to_read_completes", data_valid, 1'b1);
        chk("to_data_out", data_out, 32'hCAFEF00D);
        chk("to_read_count", 32'(read_count), 32'd13);
        repeat (5) step();
        chk1("to_sticky_in_idle", timeout, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("to_clear_on_start", timeout, 1'b0);
        step();
        step();
        chk("to_next_read_count", 32'(read_count), 32'd14);

        // Three starts while busy collapse into one extra read
        arready = 1'b0;
        rises = 0;
        start = 1'b1; step_cnt(); start = 1'b0; step_cnt();
        start = 1'b1; step_cnt(); start = 1'b0; step_cnt();
        start = 1'b1; step_cnt(); start = 1'b0; step_cnt();
        start = 1'b1; step_cnt(); start = 1'b0;
        arready = 1'b1;
        repeat (20) step_cnt();
        chk("pend_rises", 32'(rises), 32'd2);
        chk("pend_read_count", 32'(read_count), 32'd16);
        chk1("pend_idle_busy", busy, 1'b0);

        // Start coinciding with poll tick in IDLE: exactly one read
        rises = 0;
        poll_en = 1'b1;
        repeat (9) step_cnt();
        start = 1'b1;
        step_cnt();
        start = 1'b0;
        poll_en = 1'b0;
        repeat (12) step_cnt();
        chk("coinc_rises", 32'(rises), 32'd1);
        chk("coinc_read_count", 32'(read_count), 32'd17);

        // Reset asserted while in DATA
        arready = 1'b1; rvalid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk1("prerst_in_data", rready, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_arvalid", arvalid, 1'b0);
        chk1("arst_rready", rready, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk("arst_data_out", data_out, 32'h0);
        chk("arst_read_count", 32'(read_count), 32'd0);
        chk("arst_araddr", araddr, TADDR);
        step();
        step();
        rst_n = 1'b1;
        rvalid = 1'b1;
        rises = 0;
        repeat (20) step_cnt();
        chk("postrst_no_read", 32'(rises), 32'd0);
        chk("postrst_read_count", 32'(read_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_poller.md
AXI_LITE_READ_POLLER -- requirements
Module: axi_lite_read_poller

Interface
REQ-001 The block SHALL have these parameters: C_M_AXI_ADDR_WIDTH, default 32, address width; C_M_AXI_DATA_WIDTH, default 32, data width; TARGET_ADDR, default 32'h0000_0000, read address; POLL_PERIOD, default 1000, cycles between periodic reads (minimum 2); TIMEOUT_CYCLES, default 256, cycles before timeout flag (minimum 1).
REQ-002 The block SHALL have these ports, clock and reset first:
- M_AXI_ACLK  in  1  single clock, rising edge.
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-shot read request, sampled every cycle.
- poll_en  in  1  enables periodic reads.
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARADDR  out  C_M_AXI_ADDR_WIDTH  read address, always TARGET_ADDR.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RVALID  in  1  read data valid.
- M_AXI_RDATA  in  C_M_AXI_DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RREADY  out  1  read data ready.
- data_out  out  C_M_AXI_DATA_WIDTH  last good read value.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- err_pulse  out  1  one-cycle pulse when a read returns RRESP != 2'b00.
- timeout  out  1  sticky flag: a transaction exceeded TIMEOUT_CYCLES.
- busy  out  1  high while a transaction is outstanding.
- read_count  out  16  count of completed reads, good or error; wraps at 16'hFFFF.

Function
REQ-003 The FSM SHALL have three states: IDLE, ADDR and DATA. All outputs SHALL be registered.
REQ-004 In IDLE, when a trigger is present, the next state SHALL be ADDR with ARVALID=1. A trigger is start=1, a poll tick, or a pending flag.
REQ-005 In ADDR, ARVALID SHALL stay high until the cycle in which ARVALID and ARREADY are both 1; it SHALL NOT be withdrawn early. The next state SHALL then be DATA, with ARVALID=0 and RREADY=1.
REQ-006 In DATA, RREADY SHALL stay high until RVALID=1. The next state SHALL then be IDLE, with RREADY=0.
REQ-007 At RVALID&RREADY with RRESP=2'b00: data_out SHALL take RDATA and data_valid SHALL pulse on the next cycle.
REQ-008 At RVALID&RREADY with any other RRESP: data_out SHALL hold, data_valid SHALL stay 0, and err_pulse SHALL pulse on the next cycle.
REQ-009 read_count SHALL increment by 1 per completed read, good or error, in the same cycle as the data_valid or err_pulse update.
REQ-010 Latency with ARREADY and RVALID held high: start at cycle 0 gives ARVALID at cycle 1, RREADY at cycle 2, and data_valid at cycle 3. The minimum back-to-back spacing between ARVALID rises is 3 cycles.
REQ-011 Poll timer: while poll_en=1, the timer SHALL count 0..POLL_PERIOD-1 and emit a one-cycle tick on wrap. While poll_en=0, the timer SHALL clear to 0 and emit no ticks.
REQ-012 A trigger that arrives while busy SHALL set a one-deep pending flag. Further triggers while pending=1 SHALL be dropped. The flag SHALL clear when ADDR is entered.
REQ-013 Simultaneous start and tick in IDLE SHALL produce exactly one read and SHALL NOT set pending.
REQ-014 busy SHALL be 1 in ADDR and DATA, and 0 in IDLE.
REQ-015 Timeout counter: it SHALL clear on entry to ADDR and increment each cycle in ADDR or DATA. On reaching TIMEOUT_CYCLES it SHALL set timeout=1 and saturate. The transaction SHALL continue to wait for completion (no abort).
REQ-016 timeout SHALL clear only on reset or on a start pulse seen in IDLE.
REQ-017 M_AXI_ARADDR SHALL be constant TARGET_ADDR at all times, including during reset.

Reset
REQ-018 While M_AXI_ARESETN=0, asynchronously: state=IDLE; ARVALID=0; RREADY=0; data_out=0; data_valid=0; err_pulse=0; timeout=0; busy=0; read_count=0; pending=0; poll timer=0; timeout counter=0.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction. After release the block SHALL be in IDLE and SHALL NOT issue a read until a new trigger arrives.
REQ-020 The first trigger SHALL be accepted no earlier than the first clock edge after reset deasserts.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, ADDR=2'b01, DATA=2'b10) and the RRESP constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
REQ-022 The poll timer SHALL be one sub-module, poll_tick_gen, parameterised by POLL_PERIOD.
REQ-023 The FSM, capture logic and counters SHALL stay in the top module.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Constant slave returns 32'hDEADBEEF; pulse start -> data_out=32'hDEADBEEF, one data_valid pulse, read_count=1, err_pulse=0.
- Slave returns RRESP=2'b10 with RDATA=32'h12345678 -> data_out unchanged, err_pulse one cycle, read_count increments.
- poll_en=1, POLL_PERIOD=10, zero-latency slave, run 100 cycles -> exactly 10 reads, ARVALID rises 10 cycles apart.
- ARREADY held low for 300 cycles, TIMEOUT_CYCLES=256 -> ARVALID stays high throughout, timeout=1 at cycle 256 after ARVALID rise; read completes when ARREADY rises; timeout stays 1 until next start in IDLE.
- Three start pulses during one busy transaction -> exactly one extra read follows, total read_count=2.
- Reset asserted in DATA state -> all outputs at reset values asynchronously; no ARVALID after release without a trigger.
